// File: rtl/div_ctrl_pkg.sv
// Shared divide-class definitions: op codes and architectural widths used by
// the EX-stage divide controller and its neighbours.
package div_ctrl_pkg;

  localparam int INST_REG_DATA = 32;
  localparam int INST_REG_ADDR = 5;
  localparam int OP_W          = 3;

  localparam logic [OP_W-1:0] OP_DIV  = 3'b100;
  localparam logic [OP_W-1:0] OP_DIVU = 3'b101;
  localparam logic [OP_W-1:0] OP_REM  = 3'b110;
  localparam logic [OP_W-1:0] OP_REMU = 3'b111;

  localparam logic [INST_REG_DATA-1:0] ZERO_WORD = '0;

endpackage

// File: rtl/div_ctrl.sv
// EX-stage divide controller: issues one request to the iterative divider,
// stalls the pipeline meanwhile, and arbitrates the result onto the regfile port.
//
// state | meaning
// IDLE  | no divide outstanding; accept a new one when the divider is free
// ISSUE | one-cycle request pulse to the divider with registered operands
// WAIT  | waiting for the divider result pulse
// WB    | result buffered, retrying the shared write port until the ALU lets go
// DONE  | one cycle with stall released so the divide instruction retires
// DRAIN | flushed op still running in the divider; swallow its result
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int DATA_W = INST_REG_DATA,
  parameter int ADDR_W = INST_REG_ADDR
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_div_valid_i,
  input  logic [OP_W-1:0]   ex_op_code_i,
  input  logic [DATA_W-1:0] ex_data1_i,
  input  logic [DATA_W-1:0] ex_data2_i,
  input  logic [ADDR_W-1:0] ex_rd_i,
  input  logic              flush_i,
  input  logic              div_busy_i,
  input  logic              div_res_ready_i,
  input  logic [DATA_W-1:0] div_res_i,
  output logic              div_req_o,
  output logic [DATA_W-1:0] div_data1_o,
  output logic [DATA_W-1:0] div_data2_o,
  output logic [OP_W-1:0]   div_op_code_o,
  output logic [ADDR_W-1:0] div_rd_o,
  input  logic              wb_port_busy_i,
  output logic              reg_we_o,
  output logic [ADDR_W-1:0] reg_waddr_o,
  output logic [DATA_W-1:0] reg_wdata_o,
  output logic              stall_o,
  output logic              pend_valid_o,
  output logic [ADDR_W-1:0] pend_rd_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_WB    = 3'd3,
    S_DONE  = 3'd4,
    S_DRAIN = 3'd5
  } state_e;

  state_e              state_q, state_d;
  logic                req_q, req_d;
  logic [DATA_W-1:0]   data1_q, data1_d;
  logic [DATA_W-1:0]   data2_q, data2_d;
  logic [OP_W-1:0]     op_q, op_d;
  logic [ADDR_W-1:0]   rd_q, rd_d;
  logic [DATA_W-1:0]   res_q, res_d;

  logic                rd_is_zero;
  logic                in_busy_state;

  assign rd_is_zero    = (rd_q == '0);
  assign in_busy_state = (state_q == S_ISSUE) || (state_q == S_WAIT) || (state_q == S_WB);

  always_comb begin
    state_d = state_q;
    req_d   = 1'b0;
    data1_d = data1_q;
    data2_d = data2_q;
    op_d    = op_q;
    rd_d    = rd_q;
    res_d   = res_q;

    case (state_q)
      S_IDLE: begin
        if (ex_div_valid_i && !div_busy_i && !flush_i) begin
          data1_d = ex_data1_i;
          data2_d = ex_data2_i;
          op_d    = ex_op_code_i;
          rd_d    = ex_rd_i;
          req_d   = 1'b1;
          state_d = S_ISSUE;
        end
      end
      // The request pulse is already on the wire, so a flush here must drain.
      S_ISSUE: begin
        state_d = flush_i ? S_DRAIN : S_WAIT;
      end
      S_WAIT: begin
        if (flush_i) begin
          state_d = div_res_ready_i ? S_IDLE : S_DRAIN;
        end else if (div_res_ready_i) begin
          if (rd_is_zero) begin
            state_d = S_DONE;
          end else begin
            res_d   = div_res_i;
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        if (flush_i) begin
          res_d   = '0;
          state_d = S_IDLE;
        end else if (!wb_port_busy_i) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      S_DRAIN: begin
        if (div_res_ready_i) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      req_q   <= 1'b0;
      data1_q <= '0;
      data2_q <= '0;
      op_q    <= '0;
      rd_q    <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      data1_q <= data1_d;
      data2_q <= data2_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      res_q   <= res_d;
    end
  end

  assign div_req_o     = req_q;
  assign div_data1_o   = data1_q;
  assign div_data2_o   = data2_q;
  assign div_op_code_o = op_q;
  assign div_rd_o      = rd_q;

  // The ALU always owns the port when it asks; a flush in WB cancels the write.
  assign reg_we_o    = (state_q == S_WB) && !wb_port_busy_i && !flush_i;
  assign reg_waddr_o = (state_q == S_WB) ? rd_q  : '0;
  assign reg_wdata_o = (state_q == S_WB) ? res_q : '0;

  // Gated with rst_n so the stall also drops while reset is held.
  assign stall_o = rst_n &&
                   (in_busy_state ||
                    (((state_q == S_IDLE) || (state_q == S_DRAIN)) && ex_div_valid_i));

  assign pend_valid_o = in_busy_state;
  assign pend_rd_o    = in_busy_state ? rd_q : '0;

endmodule
